// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state codes and framing constants for the program loader.
package program_loader_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t HDR   = 3'd1;
    localparam state_t INSTR = 3'd2;
    localparam state_t DATA  = 3'd3;
    localparam state_t DONE  = 3'd4;
    localparam state_t ERR   = 3'd5;
    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: packs big-endian bytes into 32-bit words and flags each completed word one cycle later.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0] idx;
    // word is the shift register itself, so it holds the full word during the word_done cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= byte_valid && idx == 2'(BYTES_PER_WORD - 1);
            if (clear) begin
                idx  <= '0;
                word <= '0;
            end else if (byte_valid) begin
                idx  <= idx + 2'd1;
                word <= {word[23:0], byte_data};
            end
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: parses a framed byte image and strobes instruction words and data bytes into the core's memories.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_INSTR = 256,
    parameter int MAX_DATA  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        instruction_load,
    output logic [31:0] instruction_store,
    output logic        data_load,
    output logic [7:0]  data_store,
    output logic        ready,
    output logic        busy,
    output logic        error
);
    state_t      state;
    logic [15:0] n, m, cnt, wcnt, m_new;
    logic [23:0] hdr;
    logic        acc, clear, hdr_last, hdr_bad, word_end;

    assign busy     = state == HDR || state == INSTR || state == DATA;
    assign in_ready = busy;
    assign acc      = in_valid && in_ready;
    assign clear    = start && !busy;
    assign hdr_last = acc && state == HDR && cnt == 16'(HDR_BYTES - 1);
    assign m_new    = {hdr[7:0], in_data};
    assign hdr_bad  = hdr[23:8] == '0 || 32'(hdr[23:8]) > MAX_INSTR || 32'(m_new) > MAX_DATA;
    assign word_end = acc && state == INSTR && cnt[1:0] == 2'(BYTES_PER_WORD - 1);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .byte_valid (acc && state == INSTR),
        .byte_data  (in_data),
        .word       (instruction_store),
        .word_done  (instruction_load)
    );

    // DONE is entered on the last accepted byte, so ready lands one cycle after the final strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            n          <= '0;
            m          <= '0;
            cnt        <= '0;
            wcnt       <= '0;
            hdr        <= '0;
            data_load  <= 1'b0;
            data_store <= '0;
            ready      <= 1'b0;
            error      <= 1'b0;
        end else begin
            data_load <= acc && state == DATA;
            ready     <= state == DONE && !start;
            if (clear) begin
                state <= HDR;
                error <= 1'b0;
                cnt   <= '0;
                wcnt  <= '0;
            end else if (acc) begin
                cnt <= cnt + 16'd1;
                if (state == HDR) begin
                    hdr <= {hdr[15:0], in_data};
                    if (hdr_last) begin
                        n     <= hdr[23:8];
                        m     <= m_new;
                        cnt   <= '0;
                        state <= hdr_bad ? ERR : INSTR;
                        error <= hdr_bad;
                    end
                end else if (state == INSTR) begin
                    if (word_end) begin
                        wcnt <= wcnt + 16'd1;
                        if (wcnt + 16'd1 == n) begin
                            state <= m == '0 ? DONE : DATA;
                            cnt   <= '0;
                        end
                    end
                end else begin
                    data_store <= in_data;
                    if (cnt + 16'd1 == m) state <= DONE;
                end
            end
        end
    end
endmodule
